// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch/sequencing stage.
//   - seq_state_t : run-control FSM encoding (STOPPED / RUNNING / HALTED)
//   - OPCODE_W    : width of the opcode field taken from the top of the instruction
//   - *_DEF       : default widths for PC, instruction word and retired counter
package cpu_pkg;

  localparam int OPCODE_W    = 6;
  localparam int PC_W_DEF    = 10;
  localparam int INSTR_W_DEF = 16;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    STOPPED = 2'b00,
    RUNNING = 2'b01,
    HALTED  = 2'b10
  } seq_state_t;

endpackage

// File: rtl/fetch_seq_if.sv
// Bus between the fetch/sequencing stage and its surroundings
// (program memory, control unit, ALU, run control).
//   master : drives run, step, instr, s_inc, wez, alu_zero;
//            observes pc, opcode, z, exec_en, halted, retired, state
//   slave  : the fetch stage itself (directions reversed)
// state is the FSM state, exported for debug and checkers.
//
// Handshake: there is no valid/ready pair. exec_en is the only qualifier;
// an instruction commits on a rising edge exactly when exec_en is 1 during
// the preceding cycle, and run/step are level/pulse requests sampled on edges.
interface fetch_seq_if #(
  parameter int PC_W    = cpu_pkg::PC_W_DEF,
  parameter int INSTR_W = cpu_pkg::INSTR_W_DEF,
  parameter int CNT_W   = cpu_pkg::CNT_W_DEF
) ();
  import cpu_pkg::*;

  logic                run;
  logic                step;
  logic [INSTR_W-1:0]  instr;
  logic                s_inc;
  logic                wez;
  logic                alu_zero;
  logic [PC_W-1:0]     pc;
  logic [OPCODE_W-1:0] opcode;
  logic                z;
  logic                exec_en;
  logic                halted;
  logic [CNT_W-1:0]    retired;
  seq_state_t          state;

  modport master (
    output run, step, instr, s_inc, wez, alu_zero,
    input  pc, opcode, z, exec_en, halted, retired, state
  );

  modport slave (
    input  run, step, instr, s_inc, wez, alu_zero,
    output pc, opcode, z, exec_en, halted, retired, state
  );

endinterface

// File: rtl/fetch_seq_pc_reg.sv
// Program counter register.
//   clk, reset : clock, synchronous active-high reset (pc -> 0)
//   en         : commit enable; pc holds when low
//   s_inc      : 1 = pc+1 (wraps modulo 2^PC_W), 0 = load target
//   target     : jump target
//   pc         : current program counter
module pc_reg #(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            s_inc,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (en) begin
      pc <= s_inc ? pc + 1'b1 : target;
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Fetch/sequencing stage of the single-cycle CPU: owns the PC and the zero
// flag, provides run/stop/single-step control and halts on a jump-to-self.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_seq_if slave modport
//     in : run, step, instr, s_inc, wez, alu_zero
//     out: pc, opcode, z, exec_en, halted, retired, state
module fetch_seq
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic         clk,
  input logic         reset,
  fetch_seq_if.slave  bus
);

  seq_state_t       state_q;
  logic             exec_en;
  logic             self_jump;
  logic             z_q;
  logic             halted_q;
  logic [CNT_W-1:0] retired_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  target;

  assign target = bus.instr[PC_W-1:0];

  // Commit strobe: while stopped, a step pulse lets exactly one instruction through.
  always_comb begin
    exec_en = 1'b0;
    unique case (state_q)
      RUNNING: exec_en = 1'b1;
      STOPPED: exec_en = bus.step;
      default: exec_en = 1'b0;
    endcase
  end

  // A taken jump whose target is the current pc would loop forever; treat it as halt.
  assign self_jump = exec_en && !bus.s_inc && (target == pc_q);

  pc_reg #(.PC_W(PC_W)) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .en     (exec_en),
    .s_inc  (bus.s_inc),
    .target (target),
    .pc     (pc_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= STOPPED;
      halted_q  <= 1'b0;
      z_q       <= 1'b0;
      retired_q <= '0;
    end else begin
      if (exec_en) begin
        if (bus.wez) begin
          z_q <= bus.alu_zero;
        end
        if (retired_q != '1) begin
          retired_q <= retired_q + 1'b1;
        end
      end

      unique case (state_q)
        STOPPED: begin
          if (self_jump) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else if (bus.run) begin
            state_q <= RUNNING;
          end
        end
        RUNNING: begin
          if (self_jump) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else if (!bus.run) begin
            state_q <= STOPPED;
          end
        end
        default: begin
          state_q  <= HALTED;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pc      = pc_q;
  assign bus.opcode  = bus.instr[INSTR_W-1 -: OPCODE_W];
  assign bus.z       = z_q;
  assign bus.exec_en = exec_en;
  assign bus.halted  = halted_q;
  assign bus.retired = retired_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;
  import cpu_pkg::*;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_seq_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

  fetch_seq #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic               rst;
    logic               run;
    logic               step;
    logic [INSTR_W-1:0] instr;
    logic               s_inc;
    logic               wez;
    logic               az;
    logic               e_exec;
    logic [5:0]         e_opc;
    logic [PC_W-1:0]    e_pc;
    logic               e_z;
    logic               e_halt;
    logic [CNT_W-1:0]   e_ret;
    seq_state_t         e_st;
  } vec_t;

  vec_t vecs[$];

  // ---------------- scoreboard ----------------
  logic [PC_W-1:0] exp_q[$];
  int total;
  int bad;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic run, input logic step,
                     input logic [INSTR_W-1:0] instr, input logic s_inc,
                     input logic wez, input logic az, input logic e_exec,
                     input logic [5:0] e_opc, input logic [PC_W-1:0] e_pc,
                     input logic e_z, input logic e_halt,
                     input logic [CNT_W-1:0] e_ret, input seq_state_t e_st);
    vec_t v;
    v.rst = rst; v.run = run; v.step = step; v.instr = instr;
    v.s_inc = s_inc; v.wez = wez; v.az = az; v.e_exec = e_exec;
    v.e_opc = e_opc; v.e_pc = e_pc; v.e_z = e_z; v.e_halt = e_halt;
    v.e_ret = e_ret; v.e_st = e_st;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic run, input logic step,
                       input logic [INSTR_W-1:0] instr, input logic s_inc,
                       input logic wez, input logic az);
    reset        = rst;
    bus.run      = run;
    bus.step     = step;
    bus.instr    = instr;
    bus.s_inc    = s_inc;
    bus.wez      = wez;
    bus.alu_zero = az;
  endtask

  // Called at a falling edge: drive, check comb outputs, clock, check state.
  task automatic apply(input vec_t v, input int idx);
    drive(v.rst, v.run, v.step, v.instr, v.s_inc, v.wez, v.az);
    #1;
    check("exec_en", idx, 32'(bus.exec_en), 32'(v.e_exec));
    check("opcode", idx, 32'(bus.opcode), 32'(v.e_opc));
    exp_q.push_back(v.e_pc);
    @(posedge clk);
    @(negedge clk);
    check("pc", idx, 32'(bus.pc), 32'(exp_q.pop_front()));
    check("z", idx, 32'(bus.z), 32'(v.e_z));
    check("halted", idx, 32'(bus.halted), 32'(v.e_halt));
    check("retired", idx, 32'(bus.retired), 32'(v.e_ret));
    check("state", idx, 32'(bus.state), 32'(v.e_st));
  endtask

  // ---------------- test ----------------
  initial begin
    total = 0;
    bad   = 0;

    // rst run stp instr s_inc wez az | exec opc pc z halt ret state
    // Start run: first edge only leaves STOPPED, then 5 load-imm commits.
    add(0, 1, 0, 16'h0000, 1, 0, 0, 0, 6'd0, 10'd0, 0, 0, 16'd0, RUNNING);
    for (int i = 1; i <= 5; i++)
      add(0, 1, 0, 16'h0000, 1, 0, 0, 1, 6'd0, 10'(i), 0, 0, 16'(i), RUNNING);
    // Jump to 3, jump to 7, then jump-to-self halts.
    add(0, 1, 0, 16'h2003, 0, 0, 0, 1, 6'd8, 10'd3, 0, 0, 16'd6, RUNNING);
    add(0, 1, 0, 16'h2007, 0, 0, 0, 1, 6'd8, 10'd7, 0, 0, 16'd7, RUNNING);
    add(0, 1, 0, 16'h2007, 0, 0, 0, 1, 6'd8, 10'd7, 0, 1, 16'd8, HALTED);
    // Halted: run/step/flag writes ignored.
    for (int i = 0; i < 10; i++)
      add(0, logic'(i % 2), 1, 16'h0000, 1, 1, 1, 0, 6'd0, 10'd7, 0, 1, 16'd8, HALTED);
    // Reset out of HALTED.
    add(1, 0, 0, 16'h0000, 1, 0, 0, 0, 6'd0, 10'd0, 0, 0, 16'd0, STOPPED);
    // Single-step: pulses in cycles 2 and 6.
    for (int c = 0; c < 8; c++) begin
      logic st;
      logic [9:0] p;
      st = (c == 2) || (c == 6);
      p  = (c < 2) ? 10'd0 : (c < 6) ? 10'd1 : 10'd2;
      add(0, 0, st, 16'h0000, 1, 0, 0, st, 6'd0, p, 0, 0, 16'(p), STOPPED);
    end
    // Flag behaviour and jumps.
    add(0, 1, 0, 16'h0000, 1, 0, 0, 0, 6'd0, 10'd2, 0, 0, 16'd2, RUNNING);
    add(0, 1, 0, 16'h0000, 1, 1, 1, 1, 6'd0, 10'd3, 1, 0, 16'd3, RUNNING);
    add(0, 1, 0, 16'h0000, 1, 0, 0, 1, 6'd0, 10'd4, 1, 0, 16'd4, RUNNING);
    add(0, 1, 0, 16'h0000, 1, 1, 0, 1, 6'd0, 10'd5, 0, 0, 16'd5, RUNNING);
    add(0, 1, 0, 16'h63F0, 0, 0, 0, 1, 6'd24, 10'h3F0, 0, 0, 16'd6, RUNNING);
    // Not-taken conditional jump to self is not a halt.
    add(0, 1, 0, 16'h63F0, 1, 0, 0, 1, 6'd24, 10'h3F1, 0, 0, 16'd7, RUNNING);
    add(0, 1, 0, 16'h23FF, 0, 0, 0, 1, 6'd8, 10'h3FF, 0, 0, 16'd8, RUNNING);
    // 1023 + 1 wraps to 0.
    add(0, 1, 0, 16'h0000, 1, 0, 0, 1, 6'd0, 10'd0, 0, 0, 16'd9, RUNNING);
    // run drops: that instruction still commits, then stopped.
    add(0, 0, 0, 16'h0000, 1, 0, 0, 1, 6'd0, 10'd1, 0, 0, 16'd10, STOPPED);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 6'd0, 10'd1, 0, 0, 16'd10, STOPPED);
    // Stepped jump-to-self also halts.
    add(0, 0, 1, 16'h2001, 0, 0, 0, 1, 6'd8, 10'd1, 0, 1, 16'd11, HALTED);
    // Reset mid-program while running with a pending flag write.
    add(1, 0, 0, 16'h0000, 1, 0, 0, 0, 6'd0, 10'd0, 0, 0, 16'd0, STOPPED);
    add(0, 1, 0, 16'h0000, 1, 0, 0, 0, 6'd0, 10'd0, 0, 0, 16'd0, RUNNING);
    add(0, 1, 0, 16'h2012, 0, 1, 1, 1, 6'd8, 10'h012, 1, 0, 16'd1, RUNNING);
    add(1, 1, 0, 16'h0000, 1, 1, 1, 1, 6'd0, 10'd0, 0, 0, 16'd0, STOPPED);

    // Initial reset.
    drive(1, 0, 0, 16'h0000, 1, 0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 16'h0000, 1, 0, 0);
    #1;
    check("rst_pc", -1, 32'(bus.pc), 32'd0);
    check("rst_z", -1, 32'(bus.z), 32'd0);
    check("rst_halted", -1, 32'(bus.halted), 32'd0);
    check("rst_retired", -1, 32'(bus.retired), 32'd0);
    check("rst_state", -1, 32'(bus.state), 32'(STOPPED));
    check("rst_exec_en", -1, 32'(bus.exec_en), 32'd0);

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    // Counter saturation and pc wrap over a long run.
    drive(1, 0, 0, 16'h0000, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1, 0, 16'h0000, 1, 0, 0);
    repeat (65536) @(posedge clk);   // 1 start edge + 65535 commits
    @(negedge clk);
    check("sat_pc_a", -2, 32'(bus.pc), 32'h3FF);
    check("sat_ret_a", -2, 32'(bus.retired), 32'hFFFF);
    @(posedge clk);
    @(negedge clk);
    check("sat_pc_b", -2, 32'(bus.pc), 32'h000);
    check("sat_ret_b", -2, 32'(bus.retired), 32'hFFFF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sat_pc_c", -2, 32'(bus.pc), 32'h004);
    check("sat_ret_c", -2, 32'(bus.retired), 32'hFFFF);
    check("sat_halted", -2, 32'(bus.halted), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
